// File: rtl/draw_cmd_sequencer_if.sv
// Command-FIFO read port and draw-engine issue port of the draw command sequencer.
interface draw_cmd_sequencer_if #(
  parameter int NPRM  = 4,
  parameter int OPC_W = 8
);
  logic                  CMD_EMPTY;
  logic [31:0]           CMD_RDATA;
  logic                  CMD_RD_EN;
  logic                  ENG_VALID;
  logic                  ENG_READY;
  logic [OPC_W-1:0]      ENG_OPC;
  logic [23:0]           ENG_HDR;
  logic [32*NPRM-1:0]    ENG_PRM;
  logic                  ENG_IDLE;

  modport master (
    input  CMD_EMPTY, CMD_RDATA, ENG_READY, ENG_IDLE,
    output CMD_RD_EN, ENG_VALID, ENG_OPC, ENG_HDR, ENG_PRM
  );

  modport slave (
    output CMD_EMPTY, CMD_RDATA, ENG_READY, ENG_IDLE,
    input  CMD_RD_EN, ENG_VALID, ENG_OPC, ENG_HDR, ENG_PRM
  );
endinterface

// File: rtl/draw_cmd_sequencer.sv
// Draw-command fetch/decode sequencer: pops header + parameters from the command FIFO,
// issues assembled commands to the draw engine and reports BUSY/DONE/ERR.
module draw_cmd_sequencer #(
  parameter int NPRM  = 4,
  parameter int OPC_W = 8
) (
  input  logic                 CLK,
  input  logic                 ARSTN,
  input  logic                 EXE,
  input  logic                 SRST,
  draw_cmd_sequencer_if.master bus,
  output logic                 DRAW_BUSY,
  output logic                 DRAW_DONE,
  output logic                 DRAW_ERR,
  output logic [OPC_W-1:0]     ERR_OPC
);
  localparam int IW = $clog2(NPRM + 1);
  localparam int PW = (NPRM > 1) ? $clog2(NPRM) : 1;

  localparam logic [OPC_W-1:0] OP_NOP      = OPC_W'(8'h00);
  localparam logic [OPC_W-1:0] OP_SETFRAME = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] OP_SETAREA  = OPC_W'(8'h02);
  localparam logic [OPC_W-1:0] OP_SETCOLOR = OPC_W'(8'h03);
  localparam logic [OPC_W-1:0] OP_EODL     = OPC_W'(8'h0F);
  localparam logic [OPC_W-1:0] OP_PATBLT   = OPC_W'(8'h10);
  localparam logic [OPC_W-1:0] OP_BITBLT   = OPC_W'(8'h11);

  typedef enum logic [2:0] {
    S_IDLE, S_HRD, S_HCAP, S_PRD, S_PCAP, S_ISSUE, S_WIDLE, S_ERR
  } state_t;

  state_t                  state;
  logic                    exe_q;
  logic [IW-1:0]           cnt;
  logic [PW-1:0]           idx;
  logic                    eng_valid;
  logic [OPC_W-1:0]        eng_opc;
  logic [23:0]             eng_hdr;
  logic [NPRM-1:0][31:0]   prm_q;

  logic [OPC_W-1:0]        opc_in;
  logic [IW-1:0]           len_in;
  logic                    legal_in;

  always_comb begin
    opc_in   = bus.CMD_RDATA[31 -: OPC_W];
    len_in   = '0;
    legal_in = 1'b1;
    case (opc_in)
      OP_NOP, OP_EODL:         len_in = IW'(0);
      OP_SETFRAME, OP_SETAREA: len_in = IW'(2);
      OP_SETCOLOR:             len_in = IW'(1);
      OP_PATBLT:               len_in = IW'(3);
      OP_BITBLT:               len_in = IW'(4);
      default:                 legal_in = 1'b0;
    endcase
  end

  // Pop strobe is decoded from state so the FIFO word lands in the following capture cycle;
  // gating with the live empty flag rules out underflow.
  assign bus.CMD_RD_EN = ((state == S_HRD) || (state == S_PRD)) && !bus.CMD_EMPTY && !SRST;
  assign bus.ENG_VALID = eng_valid;
  assign bus.ENG_OPC   = eng_opc;
  assign bus.ENG_HDR   = eng_hdr;
  assign bus.ENG_PRM   = prm_q;

  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) begin
      state     <= S_IDLE;
      exe_q     <= 1'b1;  // a level still high across reset must not count as a new start
      cnt       <= '0;
      idx       <= '0;
      eng_valid <= 1'b0;
      eng_opc   <= '0;
      eng_hdr   <= '0;
      prm_q     <= '0;
      DRAW_BUSY <= 1'b0;
      DRAW_DONE <= 1'b0;
      DRAW_ERR  <= 1'b0;
      ERR_OPC   <= '0;
    end else if (SRST) begin
      state     <= S_IDLE;
      exe_q     <= 1'b1;
      cnt       <= '0;
      idx       <= '0;
      eng_valid <= 1'b0;
      eng_opc   <= '0;
      eng_hdr   <= '0;
      prm_q     <= '0;
      DRAW_BUSY <= 1'b0;
      DRAW_DONE <= 1'b0;
      DRAW_ERR  <= 1'b0;
      ERR_OPC   <= '0;
    end else begin
      exe_q     <= EXE;
      DRAW_DONE <= 1'b0;
      unique case (state)
        S_IDLE: if (EXE && !exe_q) begin
          state     <= S_HRD;
          DRAW_BUSY <= 1'b1;
        end
        S_HRD: if (!bus.CMD_EMPTY) state <= S_HCAP;
        S_HCAP: begin
          eng_opc <= opc_in;
          eng_hdr <= bus.CMD_RDATA[23:0];
          cnt     <= len_in;
          idx     <= '0;
          if (!legal_in) begin
            state     <= S_ERR;
            DRAW_ERR  <= 1'b1;
            ERR_OPC   <= opc_in;
            DRAW_BUSY <= 1'b0;
          end else if (opc_in == OP_EODL) begin
            state <= S_WIDLE;
          end else if (opc_in == OP_NOP) begin
            state <= S_HRD;
          end else if (len_in == '0) begin
            state     <= S_ISSUE;
            eng_valid <= 1'b1;
          end else begin
            state <= S_PRD;
          end
        end
        S_PRD: if (!bus.CMD_EMPTY) state <= S_PCAP;
        S_PCAP: begin
          prm_q[idx] <= bus.CMD_RDATA;
          idx        <= idx + 1'b1;
          if (IW'(idx) + IW'(1) == cnt) begin
            state     <= S_ISSUE;
            eng_valid <= 1'b1;
          end else begin
            state <= S_PRD;
          end
        end
        S_ISSUE: if (bus.ENG_READY) begin
          eng_valid <= 1'b0;
          state     <= S_HRD;
        end
        S_WIDLE: if (bus.ENG_IDLE) begin
          DRAW_DONE <= 1'b1;
          DRAW_BUSY <= 1'b0;
          state     <= S_IDLE;
        end
        S_ERR: state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_draw_cmd_sequencer.sv
// Bench for draw_cmd_sequencer: FIFO model, expected-command queue built from the opcode
// table, per-cycle compare process plus directed scenario checks.
module tb_draw_cmd_sequencer;
  localparam int NPRM  = 4;
  localparam int OPC_W = 8;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  logic exe = 1'b0;
  logic srst = 1'b0;
  logic busy, done, err;
  logic [OPC_W-1:0] err_opc;

  draw_cmd_sequencer_if #(.NPRM(NPRM), .OPC_W(OPC_W)) bus ();

  draw_cmd_sequencer #(.NPRM(NPRM), .OPC_W(OPC_W)) dut (
    .CLK(clk), .ARSTN(arstn), .EXE(exe), .SRST(srst), .bus(bus),
    .DRAW_BUSY(busy), .DRAW_DONE(done), .DRAW_ERR(err), .ERR_OPC(err_opc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Command FIFO model: data appears the cycle after the pop strobe; reset flushes it.
  logic [31:0] fifo_mem [256];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  assign bus.CMD_EMPTY = (wr_ptr == rd_ptr);

  always @(posedge clk or negedge arstn) begin
    if (!arstn || srst) begin
      rd_ptr        <= wr_ptr;
      bus.CMD_RDATA <= '0;
    end else if (bus.CMD_RD_EN && (wr_ptr != rd_ptr)) begin
      bus.CMD_RDATA <= fifo_mem[rd_ptr % 256];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 256] = w;
    wr_ptr++;
  endtask

  // Expected issued commands, in list order.
  logic [7:0]  e_opc [64];
  logic [23:0] e_hdr [64];
  logic [31:0] e_prm [64][4];
  int          e_len [64];
  int unsigned e_wr = 0;
  int unsigned e_rd = 0;
  int unsigned n_acc = 0;

  function automatic int op_len(input logic [7:0] op);
    case (op)
      8'h01, 8'h02: return 2;
      8'h03:        return 1;
      8'h10:        return 3;
      8'h11:        return 4;
      default:      return 0;
    endcase
  endfunction

  task automatic cmd(input logic [7:0] op, input logic [23:0] hdr,
                     input logic [31:0] p0, input logic [31:0] p1,
                     input logic [31:0] p2, input logic [31:0] p3, input bit hdr_only);
    logic [31:0] p [4];
    int n;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    n = op_len(op);
    push({op, hdr});
    if (!hdr_only)
      for (int k = 0; k < n; k++) push(p[k]);
    if (n > 0) begin
      e_opc[e_wr % 64] = op;
      e_hdr[e_wr % 64] = hdr;
      e_len[e_wr % 64] = n;
      for (int k = 0; k < 4; k++) e_prm[e_wr % 64][k] = p[k];
      e_wr++;
    end
  endtask

  always @(negedge clk) begin
    if (!arstn || srst) begin
      e_rd <= e_wr;
    end else begin
      if (bus.CMD_RD_EN) check("rd_en_while_empty", bus.CMD_EMPTY, 0);
      if (err) begin
        check("err_pop", bus.CMD_RD_EN, 0);
        check("err_valid", bus.ENG_VALID, 0);
        check("err_busy", busy, 0);
      end
      if (bus.ENG_VALID) begin
        check("valid_expected", (e_wr != e_rd), 1);
        if (e_wr != e_rd) begin
          check("eng_opc", bus.ENG_OPC, e_opc[e_rd % 64]);
          check("eng_hdr", bus.ENG_HDR, e_hdr[e_rd % 64]);
          for (int k = 0; k < e_len[e_rd % 64]; k++)
            check("eng_prm", bus.ENG_PRM[32*k +: 32], e_prm[e_rd % 64][k]);
          if (bus.ENG_READY) begin
            e_rd  <= e_rd + 1;
            n_acc <= n_acc + 1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start();
    exe = 1'b0;
    tick(2);
    exe = 1'b1;
  endtask

  task automatic soft_reset();
    srst = 1'b1;
    tick(1);
    srst = 1'b0;
  endtask

  task automatic wait_acc(input int unsigned target);
    for (int i = 0; i < 200 && n_acc < target; i++) tick(1);
    check("accept_timeout", (n_acc >= target), 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100 && !bus.ENG_VALID; i++) tick(1);
    check("valid_timeout", bus.ENG_VALID, 1);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_err"}, err, 0);
    check({name, "_errop"}, err_opc, 0);
    check({name, "_valid"}, bus.ENG_VALID, 0);
    check({name, "_rden"}, bus.CMD_RD_EN, 0);
    check({name, "_opc"}, bus.ENG_OPC, 0);
    check({name, "_hdr"}, bus.ENG_HDR, 0);
    check({name, "_prm_lo"}, bus.ENG_PRM[63:0], 0);
    check({name, "_prm_hi"}, bus.ENG_PRM[127:64], 0);
  endtask

  initial begin
    int lat;
    int unsigned acc0;
    bit done_early;
    bus.ENG_READY = 1'b1;
    bus.ENG_IDLE  = 1'b1;
    tick(3);
    arstn = 1'b1;
    tick(1);
    check_all_zero("reset");

    // 1: SETFRAME with two params, prefilled; header-to-valid is 2+2*len after the start edge
    cmd(8'h01, 24'h00ABCD, 32'h1000_0000, 32'h0000_0280, 32'h0, 32'h0, 1'b0);
    start();
    lat = 0;
    while (lat < 50 && !bus.ENG_VALID) begin
      tick(1);
      lat++;
    end
    check("t1_latency", lat, 7);
    check("t1_opc", bus.ENG_OPC, 8'h01);
    check("t1_prm0", bus.ENG_PRM[31:0], 32'h1000_0000);
    check("t1_prm1", bus.ENG_PRM[63:32], 32'h0000_0280);
    wait_acc(1);
    tick(1);
    check("t1_valid_drop", bus.ENG_VALID, 0);
    check("t1_busy", busy, 1);

    // 2: BITBLT then EODL, engine busy for 20 cycles
    soft_reset();
    bus.ENG_IDLE = 1'b0;
    cmd(8'h11, 24'h000011, 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004, 1'b0);
    cmd(8'h0F, 24'h000000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    start();
    wait_acc(n_acc + 1);
    done_early = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (done) done_early = 1'b1;
    end
    check("t2_no_early_done", done_early, 0);
    check("t2_busy_wait", busy, 1);
    bus.ENG_IDLE = 1'b1;
    tick(1);
    check("t2_done_pulse", done, 1);
    check("t2_busy_fall", busy, 0);
    tick(1);
    check("t2_done_single", done, 0);
    tick(5);
    check("t2_no_restart", busy, 0);

    // 3: header only, parameters arrive 50 cycles later
    soft_reset();
    cmd(8'h10, 24'h00AA55, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0, 1'b1);
    start();
    tick(50);
    check("t3_stall_busy", busy, 1);
    check("t3_stall_valid", bus.ENG_VALID, 0);
    check("t3_stall_rden", bus.CMD_RD_EN, 0);
    push(32'h1111_1111);
    push(32'h2222_2222);
    push(32'h3333_3333);
    acc0 = n_acc;
    wait_acc(acc0 + 1);

    // 4: illegal opcode
    soft_reset();
    cmd(8'h7E, 24'h123456, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    push(32'h1100_0000);
    acc0 = n_acc;
    start();
    tick(10);
    check("t4_err", err, 1);
    check("t4_err_opc", err_opc, 8'h7E);
    check("t4_busy", busy, 0);
    check("t4_no_issue", n_acc, acc0);
    check("t4_words_left", wr_ptr - rd_ptr, 1);
    soft_reset();
    check("t4_err_clr", err, 0);
    check("t4_errop_clr", err_opc, 0);

    // 5: engine back-pressure for 10 cycles
    soft_reset();
    bus.ENG_READY = 1'b0;
    cmd(8'h03, 24'h0000C3, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b0);
    push(32'h0000_0000);
    start();
    wait_valid();
    acc0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t5_valid_hold", bus.ENG_VALID, 1);
      check("t5_opc_hold", bus.ENG_OPC, 8'h03);
      check("t5_prm_hold", bus.ENG_PRM[31:0], 32'hDEAD_BEEF);
      check("t5_no_pop", wr_ptr - rd_ptr, 1);
    end
    bus.ENG_READY = 1'b1;
    wait_acc(acc0 + 1);

    // 6: soft reset mid-parameter fetch, then async reset mid-issue, EXE kept high
    soft_reset();
    cmd(8'h01, 24'h000001, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    start();
    tick(10);
    check("t6_prd_busy", busy, 1);
    soft_reset();
    check_all_zero("t6_srst");
    tick(10);
    check("t6_srst_no_restart", busy, 0);
    bus.ENG_READY = 1'b0;
    cmd(8'h02, 24'h000222, 32'h0000_0040, 32'h0000_0030, 32'h0, 32'h0, 1'b0);
    start();
    wait_valid();
    #2 arstn = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("t6_arst");
    arstn = 1'b1;
    bus.ENG_READY = 1'b1;
    tick(10);
    check("t6_arst_no_restart_busy", busy, 0);
    check("t6_arst_no_restart_valid", bus.ENG_VALID, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
